// File: rtl/mdr_handshake.sv
// mdr_handshake
// Memory data register that sits between the CPU internal buses and the
// memory M-bus. S-bus loads and A-bus drives complete in a single cycle.
// Memory reads (MMD) and writes (MDM) are multi-cycle REQ/ACK transactions.
// If MEM_ACK does not arrive within TO_CYCLES request cycles, the transaction
// is abandoned and the sticky TIMEOUT flag is raised.
module mdr_handshake #(
    parameter int WIDTH     = 16,
    parameter int TO_CYCLES = 15
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] S_bus,
    input  logic [WIDTH-1:0] M_bus,
    input  logic             SMD,
    input  logic             MMD,
    input  logic             MDM,
    input  logic             MDA,
    input  logic             MEM_ACK,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic [WIDTH-1:0] MDR_to_A,
    output logic [WIDTH-1:0] MDR_to_M,
    output logic [WIDTH-1:0] MDR_q,
    output logic             BUSY,
    output logic             TIMEOUT
);

    // The counter must be wide enough to hold TO_CYCLES itself.
    localparam int CW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic             timeout_q, timeout_d;

    // State and datapath registers; an asynchronous clear abandons any transfer in flight.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mdr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mdr_q     <= mdr_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: command arbitration in IDLE, ack/timeout handling while transferring.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdr_d     = mdr_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (MMD) begin
                    state_d   = RD;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else if (MDM) begin
                    state_d   = WR;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else if (SMD) begin
                    mdr_d = S_bus;
                end
            end
            RD, WR: begin
                if (MEM_ACK) begin
                    if (state_q == RD) begin
                        mdr_d = M_bus;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs are decoded purely from the registered state.
    always_comb begin
        MEM_REQ  = 1'b0;
        MEM_WE   = 1'b0;
        BUSY     = 1'b0;
        MDR_to_M = '0;
        case (state_q)
            RD: begin
                MEM_REQ = 1'b1;
                BUSY    = 1'b1;
            end
            WR: begin
                MEM_REQ  = 1'b1;
                MEM_WE   = 1'b1;
                BUSY     = 1'b1;
                MDR_to_M = mdr_q;
            end
            default: begin
                MEM_REQ = 1'b0;
            end
        endcase
    end

    // The A-bus path ignores the FSM so the CPU can read MDR even during a write.
    assign MDR_to_A = MDA ? mdr_q : '0;
    assign MDR_q    = mdr_q;
    assign TIMEOUT  = timeout_q;

endmodule
